// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bundle: NREQ requesters each offering one (rd, data) register write.
// Requesters hold valid with rd/data stable until the matching ready bit is seen high.
interface rf_wb_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [NREQ-1:0]        valid;
  logic [NREQ-1:0]        ready;
  logic [NREQ*ADDR_W-1:0] rd;
  logic [NREQ*DATA_W-1:0] data;

  modport master (output valid, rd, data, input ready);
  modport slave  (input valid, rd, data, output ready);
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin share of the reg-file write port among NREQ write-back requesters, with read forwarding.
// One registered write per cycle (1-cycle latency); losers are held off by keeping their ready low.
module rf_wb_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 16,
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_wb_arbiter_if.slave     req,
  output logic [ADDR_W-1:0]  rf_rd,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               rf_we,
  input  logic [ADDR_W-1:0]  rs1,
  input  logic [ADDR_W-1:0]  rs2,
  input  logic [DATA_W-1:0]  rf_rs1_data,
  input  logic [DATA_W-1:0]  rf_rs2_data,
  output logic [DATA_W-1:0]  rs1_data,
  output logic [DATA_W-1:0]  rs2_data,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  cand;
  logic              found;
  logic              xfer;
  logic              stall_hit;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (!found && req.valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign xfer      = found && rst_n;
  assign req.ready = xfer ? (NREQ'(1) << win) : '0;
  assign grant_idx = win;
  assign stall_hit = |(req.valid & ~req.ready);
  assign win_rd    = req.rd[int'(win)*ADDR_W +: ADDR_W];
  assign win_data  = req.data[int'(win)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wdata  <= '0;
      rr_ptr    <= '0;
      stall_cnt <= '0;
    end else begin
      // Writes to x0 are acknowledged but never reach the reg file.
      rf_we <= xfer && (win_rd != '0);
      if (xfer) begin
        rf_rd    <= win_rd;
        rf_wdata <= win_data;
        rr_ptr   <= (win == IDX_W'(NREQ-1)) ? '0 : win + 1'b1;
      end
      if (stall_hit && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign rs1_data = (rf_we && (rs1 != '0) && (rs1 == rf_rd)) ? rf_wdata : rf_rs1_data;
  assign rs2_data = (rf_we && (rs2 != '0) && (rs2 == rf_rd)) ? rf_wdata : rf_rs2_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// A second instance with a 2-bit stall counter shares the stimulus to exercise saturation.
module tb_rf_wb_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs1, rs2;
  logic [DW-1:0] rf_rs1_data, rf_rs2_data;

  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata, rs1_data, rs2_data;
  logic          rf_we;
  logic [1:0]    grant_idx;
  logic [15:0]   stall_cnt;

  logic [AW-1:0] rf_rd_b;
  logic [DW-1:0] rf_wdata_b, rs1_data_b, rs2_data_b;
  logic          rf_we_b;
  logic [1:0]    grant_idx_b;
  logic [1:0]    stall_cnt_b;

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0] pend;
  logic [AW-1:0]   p_rd   [NREQ];
  logic [DW-1:0]   p_data [NREQ];

  int          m_ptr;
  bit          m_we;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wdata;
  int          m_stall;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) ifc ();
  rf_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) ifc_b ();

  assign ifc_b.valid = ifc.valid;
  assign ifc_b.rd    = ifc.rd;
  assign ifc_b.data  = ifc.data;

  rf_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW), .STALL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(ifc.slave),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .rs1(rs1), .rs2(rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .grant_idx(grant_idx), .stall_cnt(stall_cnt)
  );

  rf_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW), .STALL_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(ifc_b.slave),
    .rf_rd(rf_rd_b), .rf_wdata(rf_wdata_b), .rf_we(rf_we_b),
    .rs1(rs1), .rs2(rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
    .grant_idx(grant_idx_b), .stall_cnt(stall_cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    ifc.valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      ifc.rd[i*AW +: AW]   = p_rd[i];
      ifc.data[i*DW +: DW] = p_data[i];
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model across the edge.
  task automatic tick();
    int win, best_d, d;
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0] e1, e2;
    drive();
    @(negedge clk);
    win = -1;
    best_d = NREQ;
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          d = (i - m_ptr + NREQ) % NREQ;
          if (d < best_d) begin
            best_d = d;
            win = i;
          end
        end
      end
    end
    exp_ready = (win >= 0) ? NREQ'(1 << win) : '0;
    chk("req_ready", 64'(ifc.ready), 64'(exp_ready));
    if (win >= 0) chk("grant_idx", 64'(grant_idx), 64'(win));
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_rd", 64'(rf_rd), 64'(m_rd));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    e1 = (m_we && rs1 != 0 && rs1 == m_rd) ? m_wdata : rf_rs1_data;
    e2 = (m_we && rs2 != 0 && rs2 == m_rd) ? m_wdata : rf_rs2_data;
    chk("rs1_data", 64'(rs1_data), 64'(e1));
    chk("rs2_data", 64'(rs2_data), 64'(e2));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("stall_sat", 64'(stall_cnt_b), 64'((m_stall > 3) ? 3 : m_stall));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_ptr = 0; m_we = 0; m_rd = '0; m_wdata = '0; m_stall = 0;
    end else begin
      if ((pend & ~exp_ready) != 0 && m_stall < 65535) m_stall++;
      m_we = 0;
      if (win >= 0) begin
        m_we    = (p_rd[win] != 0);
        m_rd    = p_rd[win];
        m_wdata = p_data[win];
        m_ptr   = (win + 1) % NREQ;
        pend[win] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic present_all();
    pend = '1;
    for (int i = 0; i < NREQ; i++) begin
      p_rd[i]   = AW'(i + 1);
      p_data[i] = DW'(32'h11 * (i + 1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rs1 = '0; rs2 = '0; rf_rs1_data = '0; rf_rs2_data = '0;
    m_ptr = 0; m_we = 0; m_rd = '0; m_wdata = '0; m_stall = 0;
    present_all();
    drive();
    @(posedge clk);
    #1;

    // Reset held with every requester valid.
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("rst_ready", 64'(ifc.ready), 64'(0));
      chk("rst_we", 64'(rf_we), 64'(0));
      tick();
    end
    rst_n = 1'b1;

    // All valid, held: grants rotate 0,1,2,3,0 with the write one cycle behind.
    for (int k = 0; k < 5; k++) begin
      present_all();
      drive();
      #2;
      chk("t2_grant", 64'(grant_idx), 64'(k % 4));
      if (k > 0) begin
        chk("t2_rd", 64'(rf_rd), 64'(((k - 1) % 4) + 1));
        chk("t2_wdata", 64'(rf_wdata), 64'(32'h11 * (((k - 1) % 4) + 1)));
        chk("t2_we", 64'(rf_we), 64'(1));
      end
      tick();
    end

    // Lone requester 2, then the search resumes at 3.
    pend = 4'b0100; p_rd[2] = 5'd5; p_data[2] = 32'h77;
    drive(); #2;
    chk("t3_ready", 64'(ifc.ready), 64'(4'b0100));
    tick();
    pend = '1; drive(); #2;
    chk("t3_rd", 64'(rf_rd), 64'(5));
    chk("t3_wdata", 64'(rf_wdata), 64'(32'h77));
    chk("t3_we", 64'(rf_we), 64'(1));
    chk("t3_next", 64'(grant_idx), 64'(3));
    tick();

    // Write to x0: acked, pointer advances, no write enable.
    pend = 4'b0010; p_rd[1] = 5'd0; p_data[1] = 32'hDEAD;
    drive(); #2;
    chk("t4_ready1", 64'(ifc.ready[1]), 64'(1));
    tick();
    pend = '1; drive(); #2;
    chk("t4_we", 64'(rf_we), 64'(0));
    chk("t4_next", 64'(grant_idx), 64'(2));
    tick();

    // Forwarding of the in-flight write to both read ports.
    pend = 4'b0001; p_rd[0] = 5'd4; p_data[0] = 32'h01;
    tick();
    pend = '0; rs1 = 5'd4; rs2 = 5'd4; rf_rs1_data = '0; rf_rs2_data = '0;
    drive(); #2;
    chk("t5_rs1", 64'(rs1_data), 64'(1));
    chk("t5_rs2", 64'(rs2_data), 64'(1));
    rs1 = 5'd0; rf_rs1_data = 32'h5A5A;
    #1;
    chk("t5_rs1_x0", 64'(rs1_data), 64'(32'h5A5A));
    chk("t5_rs2_hold", 64'(rs2_data), 64'(1));
    tick();

    // Stall counting from a fresh reset, then saturation of the 2-bit counter.
    rst_n = 1'b0; pend = '0;
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      pend = 4'b0011; p_rd[0] = 5'd7; p_rd[1] = 5'd8;
      tick();
    end
    #2;
    chk("t6_stall", 64'(stall_cnt), 64'(3));
    chk("t6_sat3", 64'(stall_cnt_b), 64'(3));
    for (int c = 0; c < 5; c++) begin
      pend = 4'b0011;
      tick();
    end
    #2;
    chk("t6_stall8", 64'(stall_cnt), 64'(8));
    chk("t6_sat", 64'(stall_cnt_b), 64'(3));

    // Randomized traffic with occasional mid-stream resets.
    pend = '0;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]   = 1'b1;
          p_rd[i]   = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
          p_data[i] = $urandom;
        end
      end
      case ($urandom_range(0, 2))
        0: rs1 = '0;
        1: rs1 = m_rd;
        default: rs1 = AW'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0: rs2 = '0;
        1: rs2 = m_rd;
        default: rs2 = AW'($urandom);
      endcase
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
